// File: rtl/sram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the IF fetch port and the MEM data port.
// Optional inst anti-starvation counter enabled by defining SRAM_ARB_STARVE_EN.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_we,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic        w_inst_req;
  logic        w_data_req;
  logic        w_force_inst;
  logic        w_rd_grant;
  logic        r_resp_v;
  logic        r_resp_owner;
  logic [31:0] r_inst_hold;
  logic [31:0] r_data_hold;

  // Requests are masked while reset is held so nothing reaches the SRAM.
  assign w_inst_req = inst_req & ~reset;
  assign w_data_req = data_req & ~reset;

`ifdef SRAM_ARB_STARVE_EN
  logic [3:0] r_starve_cnt;

  assign w_force_inst = (r_starve_cnt == LP_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!w_inst_req || inst_gnt) begin
      r_starve_cnt <= 4'd0;
    end else if (r_starve_cnt != LP_LIMIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_force_inst = 1'b0 & (LP_LIMIT != 4'd0);
`endif

  assign inst_gnt = w_inst_req & (~w_data_req | w_force_inst);
  assign data_gnt = w_data_req & ~inst_gnt;

  assign sram_en    = inst_gnt | data_gnt;
  assign sram_we    = data_gnt ? data_we : 4'd0;
  assign sram_wdata = data_gnt ? data_wdata : 32'd0;
  assign sram_addr  = inst_gnt ? inst_addr : (data_gnt ? data_addr : 32'd0);

  assign w_rd_grant = inst_gnt | (data_gnt & (data_we == 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_resp_v     <= 1'b0;
      r_resp_owner <= 1'b0;
    end else begin
      r_resp_v     <= w_rd_grant;
      r_resp_owner <= data_gnt;
    end
  end

  // A read in flight when reset arrives must not be reported.
  assign inst_rvalid = r_resp_v & ~r_resp_owner & ~reset;
  assign data_rvalid = r_resp_v &  r_resp_owner & ~reset;

  assign inst_rdata = inst_rvalid ? sram_rdata : r_inst_hold;
  assign data_rdata = data_rvalid ? sram_rdata : r_data_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_inst_hold <= 32'd0;
      r_data_hold <= 32'd0;
    end else begin
      if (inst_rvalid) r_inst_hold <= sram_rdata;
      if (data_rvalid) r_data_hold <= sram_rdata;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios followed by a randomized run,
// all compared against a transaction-level model of grants, memory contents and held read data.
module tb_sram_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADC0DE;
  endfunction

  function automatic logic [31:0] byte_mask(input logic [3:0] we);
    return {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  endfunction

  // Behavioural SRAM (1-cycle read latency) seen by the DUT.
  logic [31:0] sram_mem [logic [31:0]];
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we == 4'd0) begin
        sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_val(sram_addr);
      end else begin
        sram_mem[sram_addr] = ((sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_val(sram_addr))
                               & ~byte_mask(sram_we)) | (sram_wdata & byte_mask(sram_we));
      end
    end
  end

  // Reference model state
  logic [31:0] ref_mem [logic [31:0]];
  int          pend_owner = -1;   // -1 none, 0 inst, 1 data
  logic [31:0] pend_val;
  logic [31:0] exp_ihold = '0;
  logic [31:0] exp_dhold = '0;
  int          denied = 0;
  bit          rd_known = 0;

  // Observations from the most recent step, for directed checks
  logic        o_ignt, o_dgnt, o_irv, o_drv;
  logic [31:0] o_irdata, o_drdata, o_wdata;
  logic [3:0]  o_we;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    sram_mem[a] = v;
    ref_mem[a]  = v;
  endtask

  task automatic step(input bit rst_i, input bit ir, input logic [31:0] ia,
                      input bit dr, input logic [3:0] dwe, input logic [31:0] da,
                      input logic [31:0] dwd);
    int          win;
    bit          force_i;
    bit          exp_irv, exp_drv;
    logic [31:0] exp_ird, exp_drd;
    @(negedge clk);
    reset = rst_i; inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
    #1;
`ifdef SRAM_ARB_STARVE_EN
    force_i = (denied == LIMIT);
`else
    force_i = 0;
`endif
    if (rst_i) win = 0;
    else if (ir && (!dr || force_i)) win = 1;
    else if (dr) win = 2;
    else win = 0;
    chk("inst_gnt", {31'd0, inst_gnt}, {31'd0, win == 1});
    chk("data_gnt", {31'd0, data_gnt}, {31'd0, win == 2});
    chk("sram_en", {31'd0, sram_en}, {31'd0, win != 0});
    chk("sram_addr", sram_addr, win == 1 ? ia : (win == 2 ? da : 32'd0));
    chk("sram_we", {28'd0, sram_we}, {28'd0, win == 2 ? dwe : 4'd0});
    chk("sram_wdata", sram_wdata, win == 2 ? dwd : 32'd0);
    exp_irv = !rst_i && pend_owner == 0;
    exp_drv = !rst_i && pend_owner == 1;
    exp_ird = exp_irv ? pend_val : exp_ihold;
    exp_drd = exp_drv ? pend_val : exp_dhold;
    if (rd_known) begin
      chk("inst_rvalid", {31'd0, inst_rvalid}, {31'd0, exp_irv});
      chk("data_rvalid", {31'd0, data_rvalid}, {31'd0, exp_drv});
      chk("inst_rdata", inst_rdata, exp_ird);
      chk("data_rdata", data_rdata, exp_drd);
    end
    o_ignt = inst_gnt; o_dgnt = data_gnt; o_irv = inst_rvalid; o_drv = data_rvalid;
    o_irdata = inst_rdata; o_drdata = data_rdata; o_we = sram_we; o_wdata = sram_wdata;
    @(posedge clk);
    if (rst_i) begin
      pend_owner = -1; exp_ihold = '0; exp_dhold = '0; denied = 0;
      rd_known = 1;
    end else begin
      if (exp_irv) exp_ihold = pend_val;
      if (exp_drv) exp_dhold = pend_val;
      pend_owner = -1;
      if (win == 1) begin
        pend_owner = 0; pend_val = ref_rd(ia);
      end else if (win == 2 && dwe == 4'd0) begin
        pend_owner = 1; pend_val = ref_rd(da);
      end else if (win == 2) begin
        ref_mem[da] = (ref_rd(da) & ~byte_mask(dwe)) | (dwd & byte_mask(dwe));
      end
      if (!ir || win == 1) denied = 0;
      else if (denied < LIMIT) denied++;
    end
  endtask

  task automatic idle();
    step(0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0);
  endtask

  logic [9:0] gpat;
  logic [9:0] exp_pat;
  logic [31:0] ra, rb;

  initial begin
    reset = 1; inst_req = 0; inst_addr = '0; data_req = 0;
    data_we = '0; data_addr = '0; data_wdata = '0;

    // Reset with both requests high
    step(1, 1, 32'h1c000040, 1, 4'd0, 32'h1c000080, 32'd0);
    chk("rst_ignt", {31'd0, o_ignt}, 32'd0);
    chk("rst_dgnt", {31'd0, o_dgnt}, 32'd0);
    step(1, 1, 32'h1c000040, 1, 4'd0, 32'h1c000080, 32'd0);
    idle();
    chk("rst_irdata", o_irdata, 32'd0);
    chk("rst_drdata", o_drdata, 32'd0);

    // Inst only read
    preload(32'h1c000000, 32'h02800413);
    step(0, 1, 32'h1c000000, 0, 4'd0, 32'd0, 32'd0);
    chk("ionly_gnt", {31'd0, o_ignt}, 32'd1);
    idle();
    chk("ionly_rvalid", {31'd0, o_irv}, 32'd1);
    chk("ionly_rdata", o_irdata, 32'h02800413);
    idle();
    chk("ionly_hold", o_irdata, 32'h02800413);

    // Read/read conflict
    preload(32'h1c001000, 32'hCAFEF00D);
    step(0, 1, 32'h1c000010, 1, 4'd0, 32'h1c001000, 32'd0);
    chk("conf_dgnt", {31'd0, o_dgnt}, 32'd1);
    chk("conf_ignt", {31'd0, o_ignt}, 32'd0);
    idle();
    chk("conf_drdata", o_drdata, 32'hCAFEF00D);
    chk("conf_irdata", o_irdata, 32'h02800413);

    // Data write, then read back merged bytes
    step(0, 1, 32'h1c000000, 1, 4'b0011, 32'h1c001000, 32'h12345678);
    chk("wr_sram_we", {28'd0, o_we}, 32'h3);
    chk("wr_sram_wdata", o_wdata, 32'h12345678);
    idle();
    chk("wr_no_irv", {31'd0, o_irv}, 32'd0);
    chk("wr_no_drv", {31'd0, o_drv}, 32'd0);
    step(0, 0, 32'd0, 1, 4'd0, 32'h1c001000, 32'd0);
    idle();
    chk("wr_readback", o_drdata, 32'hCAFE5678);

    // Starvation pattern with both requests held
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 32'h1c000000, 1, 4'd0, 32'h1c001000, 32'd0);
      gpat[i] = o_ignt;
    end
`ifdef SRAM_ARB_STARVE_EN
    exp_pat = 10'b10_0001_0000;
`else
    exp_pat = 10'b00_0000_0000;
`endif
    chk("starve_pattern", {22'd0, gpat}, {22'd0, exp_pat});
    idle();

    // Alternating inst, data, inst reads
    step(0, 1, 32'h1c000004, 0, 4'd0, 32'd0, 32'd0);
    step(0, 0, 32'd0, 1, 4'd0, 32'h1c000008, 32'd0);
    chk("alt_irv1", {31'd0, o_irv}, 32'd1);
    chk("alt_ird1", o_irdata, init_val(32'h1c000004));
    step(0, 1, 32'h1c00000c, 0, 4'd0, 32'd0, 32'd0);
    chk("alt_drv", {31'd0, o_drv}, 32'd1);
    chk("alt_drd", o_drdata, init_val(32'h1c000008));
    idle();
    chk("alt_ird2", o_irdata, init_val(32'h1c00000c));

    // Reset arriving while a read is in flight
    step(0, 1, 32'h1c000000, 0, 4'd0, 32'd0, 32'd0);
    step(1, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0);
    chk("midrst_irv", {31'd0, o_irv}, 32'd0);
    idle();
    chk("midrst_irdata", o_irdata, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      ra = 32'h1c000000 + ($urandom_range(0, 15) << 2);
      rb = 32'h1c000000 + ($urandom_range(0, 15) << 2);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0, ra,
           $urandom_range(0, 2) != 0, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom),
           rb, $urandom);
    end
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
